// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if -- CPU memory-stage side of the SRAM controller.
//
// One access at a time over a req/ack handshake.
//   req    master -> slave  access request, held until ack
//   we     master -> slave  1 = write, 0 = read
//   addr   master -> slave  byte address (bits [1:0] ignored)
//   sel    master -> slave  byte enables for writes (bit i = byte lane i)
//   wdata  master -> slave  write data
//   rdata  slave -> master  read data, valid while ack=1 on a read
//   ack    slave -> master  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface sram_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl -- initiator for two asynchronous SRAM banks (base and ext).
//
// Accepts one access from the CPU interface, picks a bank from byte address
// bit ADDR_W+2, and sequences that bank's active-low ce/oe/we, address and
// bidirectional data pins. Sub-word writes become read-modify-write because
// the SRAMs have no byte enables. Every pin and ack is a register output.
//
// Ports
//   clk            sole clock
//   rst            asynchronous, active-low reset
//   cpu            sram_ctrl_if.slave (req/we/addr/sel/wdata in, rdata/ack out)
//   base_ram_*     base bank: addr, ce, oe, we (active-low), data (inout)
//   ext_ram_*      ext bank:  addr, ce, oe, we (active-low), data (inout)
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        cpu,

    output logic [ADDR_W-1:0] base_ram_addr,
    output logic              base_ram_ce,
    output logic              base_ram_oe,
    output logic              base_ram_we,
    inout  wire  [31:0]       base_ram_data,

    output logic [ADDR_W-1:0] ext_ram_addr,
    output logic              ext_ram_ce,
    output logic              ext_ram_oe,
    output logic              ext_ram_we,
    inout  wire  [31:0]       ext_ram_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                bank_q;
    logic [3:0]          sel_q;
    logic [31:0]         wdata_q;
    logic [31:0]         wr_word_q;
    logic [31:0]         rdata_q;
    logic                ack_q;
    // Per-bank pin registers, index 0 = base, 1 = ext.
    logic [1:0]          ce_n_q;
    logic [1:0]          oe_n_q;
    logic [1:0]          we_n_q;
    logic [1:0]          drive_q;

    logic [31:0]         bus_in;
    logic [31:0]         merged;
    logic [1:0]          new_bank_oh;

    // Address bits that never reach the pins.
    wire unused_addr = ^{cpu.addr[31:ADDR_W+3], cpu.addr[1:0]};

    assign new_bank_oh = cpu.addr[ADDR_W+2] ? 2'b10 : 2'b01;
    assign bus_in      = bank_q ? ext_ram_data : base_ram_data;

    // Merged write word: enabled lanes from wdata, others from the SRAM read.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = sel_q[gi] ? wdata_q[8*gi +: 8]
                                                 : bus_in[8*gi +: 8];
        end
    endgenerate

    // Pin values are set on the edge entering a state so the registered
    // outputs are active exactly for the duration of that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            bank_q    <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
            wr_word_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            ce_n_q    <= 2'b11;
            oe_n_q    <= 2'b11;
            we_n_q    <= 2'b11;
            drive_q   <= 2'b00;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu.req) begin
                        addr_q  <= cpu.addr[ADDR_W+1:2];
                        bank_q  <= cpu.addr[ADDR_W+2];
                        sel_q   <= cpu.sel;
                        wdata_q <= cpu.wdata;
                        if (!cpu.we) begin
                            state_q <= READ;
                            ce_n_q  <= ~new_bank_oh;
                            oe_n_q  <= ~new_bank_oh;
                        end else if (cpu.sel == 4'b1111) begin
                            state_q   <= WRITE;
                            ce_n_q    <= ~new_bank_oh;
                            we_n_q    <= ~new_bank_oh;
                            drive_q   <= new_bank_oh;
                            wr_word_q <= cpu.wdata;
                        end else if (cpu.sel == 4'b0000) begin
                            // Nothing to write: complete without touching pins.
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= RMW_RD;
                            ce_n_q  <= ~new_bank_oh;
                            oe_n_q  <= ~new_bank_oh;
                        end
                    end
                end
                READ: begin
                    rdata_q <= bus_in;
                    ce_n_q  <= 2'b11;
                    oe_n_q  <= 2'b11;
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end
                RMW_RD: begin
                    // Turn the bus around: oe released on the same edge that
                    // enables our drivers; ce stays low across both cycles.
                    wr_word_q <= merged;
                    oe_n_q    <= 2'b11;
                    we_n_q    <= bank_q ? 2'b01 : 2'b10;
                    drive_q   <= bank_q ? 2'b10 : 2'b01;
                    state_q   <= RMW_WR;
                end
                WRITE, RMW_WR: begin
                    ce_n_q  <= 2'b11;
                    we_n_q  <= 2'b11;
                    drive_q <= 2'b00;
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu.rdata = rdata_q;
    assign cpu.ack   = ack_q;

    assign base_ram_addr = addr_q;
    assign base_ram_ce   = ce_n_q[0];
    assign base_ram_oe   = oe_n_q[0];
    assign base_ram_we   = we_n_q[0];
    assign base_ram_data = drive_q[0] ? wr_word_q : {32{1'bz}};

    assign ext_ram_addr  = addr_q;
    assign ext_ram_ce    = ce_n_q[1];
    assign ext_ram_oe    = oe_n_q[1];
    assign ext_ram_we    = we_n_q[1];
    assign ext_ram_data  = drive_q[1] ? wr_word_q : {32{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl -- self-checking bench for sram_ctrl.
//
// Two small behavioural SRAM models sit on the bank pins. A driver issues
// CPU accesses and pushes the expected ack cycle and read data onto a
// scoreboard queue; a monitor pops an entry on every ack and compares.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int ADDR_W = 20;

    logic              clk;
    logic              rst;
    logic              probe_en;

    logic [ADDR_W-1:0] base_ram_addr, ext_ram_addr;
    logic              base_ram_ce, base_ram_oe, base_ram_we;
    logic              ext_ram_ce, ext_ram_oe, ext_ram_we;
    wire  [31:0]       base_ram_data;
    wire  [31:0]       ext_ram_data;

    sram_ctrl_if cpu_bus();

    sram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu           (cpu_bus),
        .base_ram_addr (base_ram_addr),
        .base_ram_ce   (base_ram_ce),
        .base_ram_oe   (base_ram_oe),
        .base_ram_we   (base_ram_we),
        .base_ram_data (base_ram_data),
        .ext_ram_addr  (ext_ram_addr),
        .ext_ram_ce    (ext_ram_ce),
        .ext_ram_oe    (ext_ram_oe),
        .ext_ram_we    (ext_ram_we),
        .ext_ram_data  (ext_ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM models ----------------
    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];

    assign base_ram_data = (!base_ram_ce && !base_ram_oe && base_ram_we)
                           ? base_mem[base_ram_addr[7:0]] : {32{1'bz}};
    assign ext_ram_data  = (!ext_ram_ce && !ext_ram_oe && ext_ram_we)
                           ? ext_mem[ext_ram_addr[7:0]] : {32{1'bz}};

    // Bus probe: drives zeros while enabled, so any controller drive shows up.
    assign base_ram_data = probe_en ? 32'h0 : {32{1'bz}};
    assign ext_ram_data  = probe_en ? 32'h0 : {32{1'bz}};

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) begin
                base_mem[i] <= 32'h0B00_0000 | i;
                ext_mem[i]  <= 32'h0;
            end
            base_mem[8'h10] <= 32'hDEADBEEF;
            base_mem[8'h20] <= 32'hAABBCCDD;
        end else begin
            if (!base_ram_ce && !base_ram_we) base_mem[base_ram_addr[7:0]] <= base_ram_data;
            if (!ext_ram_ce && !ext_ram_we)   ext_mem[ext_ram_addr[7:0]]   <= ext_ram_data;
        end
    end

    // ---------------- counters ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int base_ce_cnt = 0, base_oe_cnt = 0, base_we_cnt = 0;
    int ext_ce_cnt = 0, ext_oe_cnt = 0, ext_we_cnt = 0;
    always @(negedge clk) begin
        if (!base_ram_ce) base_ce_cnt <= base_ce_cnt + 1;
        if (!base_ram_oe) base_oe_cnt <= base_oe_cnt + 1;
        if (!base_ram_we) base_we_cnt <= base_we_cnt + 1;
        if (!ext_ram_ce)  ext_ce_cnt  <= ext_ce_cnt + 1;
        if (!ext_ram_oe)  ext_oe_cnt  <= ext_oe_cnt + 1;
        if (!ext_ram_we)  ext_we_cnt  <= ext_we_cnt + 1;
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        bit          is_read;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (rst && cpu_bus.ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("txn %s ack@%0d rdata=%h", e.tag, cyc, cpu_bus.rdata);
                check({e.tag, "_ack_cyc"}, cyc, e.ack_cyc);
                if (e.is_read) check({e.tag, "_rdata"}, cpu_bus.rdata, e.rdata);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge with the controller idle; lat = cycles from the
    // sampling edge to the ack cycle.
    task automatic start(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         input bit rd, input logic [31:0] exp_rd, input int lat);
        exp_t e;
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = w;
        cpu_bus.addr  = a;
        cpu_bus.sel   = s;
        cpu_bus.wdata = d;
        e.tag = tag; e.is_read = rd; e.rdata = exp_rd; e.ack_cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (cpu_bus.ack) break;
        end
        if (!cpu_bus.ack) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic single(input string tag, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input bit rd, input logic [31:0] exp_rd, input int lat);
        @(negedge clk);
        start(tag, w, a, s, d, rd, exp_rd, lat);
        wait_ack(tag);
        cpu_bus.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_base_pins"}, {29'd0, base_ram_ce, base_ram_oe, base_ram_we}, 32'd7);
        check({tag, "_ext_pins"},  {29'd0, ext_ram_ce, ext_ram_oe, ext_ram_we},    32'd7);
        check({tag, "_base_bus"},  base_ram_data, 32'h0);
        check({tag, "_ext_bus"},   ext_ram_data,  32'h0);
        check({tag, "_ack"},       {31'd0, cpu_bus.ack}, 32'd0);
        check({tag, "_rdata"},     cpu_bus.rdata, 32'h0);
    endtask

    int b_ce, b_oe, b_we, e_ce, e_we;

    task automatic snap();
        b_ce = base_ce_cnt; b_oe = base_oe_cnt; b_we = base_we_cnt;
        e_ce = ext_ce_cnt;  e_we = ext_we_cnt;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        probe_en = 1'b1;
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0;
        cpu_bus.sel = '0;   cpu_bus.wdata = '0;
        repeat (3) @(negedge clk);
        check_idle_pins("reset");
        check("reset_base_addr", {12'd0, base_ram_addr}, 32'd0);
        check("reset_ext_addr",  {12'd0, ext_ram_addr},  32'd0);
        probe_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Full read from base word 0x10.
        snap();
        single("read_base", 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, 2);
        check("read_base_ce_cycles", base_ce_cnt - b_ce, 32'd1);
        check("read_base_oe_cycles", base_oe_cnt - b_oe, 32'd1);
        check("read_ext_ce_cycles",  ext_ce_cnt - e_ce,  32'd0);

        // Full write to ext, then read back.
        snap();
        single("write_ext", 1'b1, (32'd1 << 22) | 32'h8, 4'hF, 32'h12345678, 1'b0, 32'h0, 2);
        check("write_ext_we_cycles", ext_we_cnt - e_we, 32'd1);
        check("write_base_ce_cycles", base_ce_cnt - b_ce, 32'd0);
        check("write_ext_mem", ext_mem[2], 32'h12345678);
        single("read_ext", 1'b0, (32'd1 << 22) | 32'h8, 4'h0, 32'h0, 1'b1, 32'h12345678, 2);
        check("base_word2_unchanged", base_mem[2], 32'h0B000002);

        // Partial write: read-modify-write.
        snap();
        single("rmw_base", 1'b1, 32'h80, 4'b0101, 32'h11223344, 1'b0, 32'h0, 3);
        check("rmw_mem", base_mem[8'h20], 32'hAA22CC44);
        check("rmw_ce_cycles", base_ce_cnt - b_ce, 32'd2);
        check("rmw_oe_cycles", base_oe_cnt - b_oe, 32'd1);
        check("rmw_we_cycles", base_we_cnt - b_we, 32'd1);

        // Zero-sel write: ack only.
        snap();
        single("zero_sel", 1'b1, 32'h80, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0, 1);
        check("zero_sel_base_ce", base_ce_cnt - b_ce, 32'd0);
        check("zero_sel_ext_ce",  ext_ce_cnt - e_ce,  32'd0);
        check("zero_sel_mem", base_mem[8'h20], 32'hAA22CC44);

        // Back-to-back reads with req held high.
        @(negedge clk);
        start("b2b0", 1'b0, 32'h44, 4'h0, 32'h0, 1'b1, 32'h0B000011, 2);
        begin
            exp_t e;
            e.tag = "b2b1"; e.is_read = 1'b1; e.rdata = 32'h0B000012; e.ack_cyc = cyc + 5;
            sb.push_back(e);
            e.tag = "b2b2"; e.is_read = 1'b1; e.rdata = 32'h0B000013; e.ack_cyc = cyc + 8;
            sb.push_back(e);
        end
        wait_ack("b2b0");
        cpu_bus.addr = 32'h48;
        wait_ack("b2b1");
        cpu_bus.addr = 32'h4C;
        wait_ack("b2b2");
        cpu_bus.req = 1'b0;
        @(negedge clk);

        // Reset in the middle of the RMW drive cycle.
        @(negedge clk);
        start("rmw_reset", 1'b1, 32'hC0, 4'b0011, 32'h55667788, 1'b0, 32'h0, 3);
        n = 0;
        while (n < 10 && !(!base_ram_ce && !base_ram_we)) begin
            @(negedge clk);
            n++;
        end
        check("rmw_wr_reached", {31'd0, ~base_ram_we}, 32'd1);
        rst = 1'b0;
        probe_en = 1'b1;
        #1;
        check_idle_pins("mid_reset");
        sb.delete();
        cpu_bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        probe_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        single("read_after_reset", 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, 2);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

SRAM initiator between the CPU memory stage and the two off-chip asynchronous SRAM banks (base and ext). Accepts one word- or byte-enabled access at a time over a req/ack handshake, selects a bank from the address, and drives that bank's active-low ce/oe/we, address and bidirectional data pins. Sub-word writes become read-modify-write sequences, because the SRAM banks have no byte-enable pins.

## Interface
- ADDR_W, 20, SRAM word-address width per bank; byte address bit ADDR_W+2 selects the bank.
- DATA_W, 32, data width; fixed at 32 because sel is 4 bits.

Clock, reset and CPU side:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; latched with req.
- addr  input  32  byte address; addr[1:0] ignored.
- sel  input  4  byte enables for writes (bit i = byte i, little-endian lanes); ignored for reads.
- wdata  input  32  write data; latched with req.
- rdata  output  32  read data; valid while ack=1 on a read.
- ack  output  1  one-cycle completion pulse.

Each SRAM bank (prefix base_ram_ / ext_ram_):
- *_addr  output  ADDR_W  word address = addr[ADDR_W+1:2].
- *_ce  output  1  chip enable, active-low.
- *_oe  output  1  output enable, active-low.
- *_we  output  1  write enable, active-low.
- *_data  inout  32  driven only in write states, otherwise 32'hZZZZZZZZ.

## Operation
- States: IDLE, READ, WRITE, RMW_RD, RMW_WR, DONE.
- IDLE with req=1: latch addr, we, sel and wdata; latch bank = addr[ADDR_W+2] (0 = base, 1 = ext). Next state:
  - we=0 → READ.
  - we=1 and sel=4'b1111 → WRITE.
  - we=1 and sel=4'b0000 → DONE; no pin activity.
  - we=1 with any other sel → RMW_RD.
- IDLE with req=0: stay in IDLE.
- READ / RMW_RD:
  - Selected bank: ce=0, oe=0, we=1, data bus released.
  - At the edge leaving the state, sample the bus into an internal word register.
  - READ → DONE, with the sampled word in rdata. RMW_RD → RMW_WR, with the sampled word as the merge source.
- WRITE / RMW_WR:
  - Selected bank: ce=0, oe=1, we=0.
  - Data pins driven with wdata (WRITE) or the merged word (RMW_WR). Merged byte i = sel[i] ? wdata byte i : read byte i.
  - The SRAM captures the word on the edge leaving the state; next state DONE.
- DONE: ack=1 for exactly this cycle; next state IDLE unconditionally.
- Unselected bank: ce=oe=we=1 and data high-Z in every state.
- Bank address pins are registered; both banks' address outputs carry the latched word address (don't-care when ce=1).
- Reset (rst=0, any state, mid-transaction included): state=IDLE; all ce/oe/we=1; both data buses high-Z; both addr=0; rdata=0; ack=0. An interrupted write has an undefined effect on SRAM contents.

## Timing
- All pin and ack outputs are registered; no combinational path from req to the pins.
- Latency from the edge that samples req to the ack cycle:
  - read or full-word write: 2 cycles (one pin-active cycle, then DONE);
  - zero-sel write: 1 cycle;
  - partial write: 3 cycles.
- rdata holds its value after ack until the next read completes.
- Handshake:
  - The master holds req, we, addr, sel and wdata stable until ack.
  - The master lowers req in the ack cycle, or re-raises it to start a new access.
  - req high in the IDLE cycle after DONE starts a new transaction, so back-to-back reads run at 1 ack every 3 cycles.
- Bus turnaround: in RMW the READ cycle (oe=0, we=1) is directly followed by the drive cycle (oe=1, we=0). The controller never drives data while oe=0.

## Test plan
- Full read: preload base word 0x10 = 32'hDEADBEEF; req=1, we=0, addr=32'h40 → base_ce/base_oe low for 1 cycle, ext pins idle; ack 2 cycles after accept; rdata = DEADBEEF.
- Full write then read to ext: write 32'h12345678 at addr = (1<<22)|32'h8, sel=F → ext_we low 1 cycle, ack at +2. A follow-up read of the same address returns 12345678, and base memory is unchanged.
- Partial write: base word = 32'hAABBCCDD; write wdata = 32'h11223344, sel=4'b0101 → RMW sequence, ack at +3; memory = 32'hAA22CC44.
- Zero-sel write: sel=0 → ack at +1; no ce activity on either bank; memory unchanged.
- Back-to-back: req held high across 3 reads at consecutive words → 3 ack pulses exactly 3 cycles apart, each with the correct data.
- Reset mid-RMW: assert rst low during RMW_WR → all ce/oe/we high and both buses high-Z immediately, without waiting for an edge; ack=0 and rdata=0. After release, the next read completes normally.
